irq_ctrl: RTL and testbench

- Interrupt scheduler between peripheral strobes (PS/2 keyboard, mouse, internal timer) and the CPU toggle-style IRQ inputs IRQ_KEYB, IRQ_MOUSE and IRQ_TIMER.
- Latches requests, masks them, and delivers one interrupt at a time in fixed priority.
- Delivery is blocked until software acknowledges the previous interrupt, so no toggle is ever lost by double-flipping.
- Configured via a 4-byte register window snooped from the CPU memory bus; it also contains the programmable millisecond timer.

---
 rtl/irq_pkg.sv | 27 ++
 rtl/irq_timer.sv | 64 ++++++
 rtl/irq_ctrl.sv | 122 ++++++++++++
 tb/tb_irq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pkg
//  Purpose  : Shared constants and helpers for the interrupt controller.
//  Revision : 1.0  initial release
// ============================================================================
package irq_pkg;

    localparam int NSRC      = 3;
    localparam int SRC_KEYB  = 0;
    localparam int SRC_MOUSE = 1;
    localparam int SRC_TIMER = 2;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_TLO  = 2'd1;
    localparam logic [1:0] REG_THI  = 2'd2;
    localparam logic [1:0] REG_ACK  = 2'd3;

    localparam int ACK_OVR_BIT = 7;

    // Isolates the lowest set bit, which is also the highest-priority source.
    function automatic logic [NSRC-1:0] pick_lowest(input logic [NSRC-1:0] v);
        return v & (~v + 3'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : irq_timer
//  Purpose  : Prescaler plus programmable period counter, one-cycle fire.
//  Revision : 1.0  initial release
// ============================================================================
module irq_timer
    import irq_pkg::*;
#(
    parameter int PRESCALE = 25000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        commit,
    input  logic [15:0] period,
    output logic        fire
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] C_PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_presc_q;
    logic [PW-1:0] w_presc_d;
    logic [15:0]   r_tcount_q;
    logic [15:0]   w_tcount_d;
    logic          w_tick;

    assign w_tick = (period != 16'd0) && (r_presc_q == C_PRE_LAST);

    // A commit restarts the whole interval and suppresses a coincident fire.
    always_comb begin
        w_presc_d  = r_presc_q;
        w_tcount_d = r_tcount_q;
        fire       = 1'b0;
        if (commit) begin
            w_presc_d  = '0;
            w_tcount_d = period;
        end else if (period == 16'd0) begin
            w_presc_d  = '0;
        end else if (w_tick) begin
            w_presc_d = '0;
            if (r_tcount_q <= 16'd1) begin
                fire       = 1'b1;
                w_tcount_d = period;
            end else begin
                w_tcount_d = r_tcount_q - 16'd1;
            end
        end else begin
            w_presc_d = r_presc_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_presc_q  <= '0;
            r_tcount_q <= '0;
        end else begin
            r_presc_q  <= w_presc_d;
            r_tcount_q <= w_tcount_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : Latches, masks and delivers peripheral interrupts one at a time
//             as toggles; bus-snooped register window and millisecond timer.
//  Revision : 1.0  initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFFF0,
    parameter int          PRESCALE  = 25000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [15:0] I_ADDR,
    input  logic [7:0]  I_WDATA,
    input  logic        I_WREN,
    output logic [7:0]  O_RDATA,
    output logic        O_RSEL,
    input  logic        KEYB_STB,
    input  logic        MOUSE_STB,
    output logic        IRQ_KEYB,
    output logic        IRQ_MOUSE,
    output logic        IRQ_TIMER
);

    logic [NSRC-1:0] r_mask_q,     w_mask_d;
    logic [NSRC-1:0] r_pending_q,  w_pending_d;
    logic [NSRC-1:0] r_inflight_q, w_inflight_d;
    logic [NSRC-1:0] r_overrun_q,  w_overrun_d;
    logic [NSRC-1:0] r_irq_q,      w_irq_d;
    logic [7:0]      r_tlo_q,      w_tlo_d;
    logic [15:0]     r_tperiod_q,  w_tperiod_d;

    logic [15:0]     w_off;
    logic [1:0]      w_reg;
    logic            w_wr;
    logic            w_commit;
    logic            w_fire;
    logic [NSRC-1:0] w_stb;
    logic [NSRC-1:0] w_ack;
    logic            w_ack_ovr;
    logic [NSRC-1:0] w_sel;

    // Unsigned offset wraps, so one compare covers both window edges.
    assign w_off    = I_ADDR - BASE_ADDR;
    assign O_RSEL   = (w_off < 16'd4);
    assign w_reg    = w_off[1:0];
    assign w_wr     = I_WREN && O_RSEL;
    assign w_commit = w_wr && (w_reg == REG_THI);

    assign w_tperiod_d = w_commit ? {I_WDATA, r_tlo_q} : r_tperiod_q;

    irq_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .commit (w_commit),
        .period (w_tperiod_d),
        .fire   (w_fire)
    );

    always_comb begin
        w_stb            = '0;
        w_stb[SRC_KEYB]  = KEYB_STB;
        w_stb[SRC_MOUSE] = MOUSE_STB;
        w_stb[SRC_TIMER] = w_fire;

        w_ack     = (w_wr && w_reg == REG_ACK) ? I_WDATA[NSRC-1:0] : '0;
        w_ack_ovr = w_wr && (w_reg == REG_ACK) && I_WDATA[ACK_OVR_BIT];

        w_sel = (r_inflight_q == '0) ? pick_lowest(r_pending_q & r_mask_q) : '0;

        w_mask_d     = (w_wr && w_reg == REG_MASK) ? I_WDATA[NSRC-1:0] : r_mask_q;
        w_tlo_d      = (w_wr && w_reg == REG_TLO) ? I_WDATA : r_tlo_q;
        w_pending_d  = (r_pending_q & ~w_sel) | w_stb;
        w_inflight_d = (r_inflight_q & ~w_ack) | w_sel;
        // A strobe landing on a pending bit that is being delivered is not lost.
        w_overrun_d  = (w_ack_ovr ? '0 : r_overrun_q) | (w_stb & r_pending_q & ~w_sel);
        w_irq_d      = r_irq_q ^ w_sel;
    end

    always_comb begin
        O_RDATA = 8'h00;
        if (O_RSEL) begin
            case (w_reg)
                REG_MASK: O_RDATA = {1'b0, r_pending_q, 1'b0, r_mask_q};
                REG_TLO:  O_RDATA = r_tperiod_q[7:0];
                REG_THI:  O_RDATA = r_tperiod_q[15:8];
                default:  O_RDATA = {1'b0, r_overrun_q, 1'b0, r_inflight_q};
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_mask_q     <= '0;
            r_pending_q  <= '0;
            r_inflight_q <= '0;
            r_overrun_q  <= '0;
            r_irq_q      <= '0;
            r_tlo_q      <= '0;
            r_tperiod_q  <= '0;
        end else begin
            r_mask_q     <= w_mask_d;
            r_pending_q  <= w_pending_d;
            r_inflight_q <= w_inflight_d;
            r_overrun_q  <= w_overrun_d;
            r_irq_q      <= w_irq_d;
            r_tlo_q      <= w_tlo_d;
            r_tperiod_q  <= w_tperiod_d;
        end
    end

    assign IRQ_KEYB  = r_irq_q[SRC_KEYB];
    assign IRQ_MOUSE = r_irq_q[SRC_MOUSE];
    assign IRQ_TIMER = r_irq_q[SRC_TIMER];

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl
//  Purpose  : Directed vector table plus timer/reset sequences for irq_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_irq_ctrl;

    localparam logic [15:0] A0 = 16'hFFF0;
    localparam logic [15:0] A1 = 16'hFFF1;
    localparam logic [15:0] A2 = 16'hFFF2;
    localparam logic [15:0] A3 = 16'hFFF3;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [15:0] I_ADDR;
    logic [7:0]  I_WDATA;
    logic        I_WREN;
    logic [7:0]  O_RDATA;
    logic        O_RSEL;
    logic        KEYB_STB;
    logic        MOUSE_STB;
    logic        IRQ_KEYB;
    logic        IRQ_MOUSE;
    logic        IRQ_TIMER;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wren;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        k;
        logic        m;
        logic [2:0]  irq;
        logic        rsel;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vq[$];

    irq_ctrl #(
        .BASE_ADDR (16'hFFF0),
        .PRESCALE  (4)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .I_ADDR    (I_ADDR),
        .I_WDATA   (I_WDATA),
        .I_WREN    (I_WREN),
        .O_RDATA   (O_RDATA),
        .O_RSEL    (O_RSEL),
        .KEYB_STB  (KEYB_STB),
        .MOUSE_STB (MOUSE_STB),
        .IRQ_KEYB  (IRQ_KEYB),
        .IRQ_MOUSE (IRQ_MOUSE),
        .IRQ_TIMER (IRQ_TIMER)
    );

    always #10 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [15:0] a, input logic [7:0] d,
                       input logic k, input logic m, input logic [2:0] irq,
                       input logic rsel, input logic [7:0] rd);
        vec_t t;
        t.wren = w; t.addr = a; t.wdata = d; t.k = k; t.m = m;
        t.irq = irq; t.rsel = rsel; t.rdata = rd;
        vq.push_back(t);
    endtask

    task automatic step;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drive(input logic w, input logic [15:0] a, input logic [7:0] d,
                         input logic k, input logic m);
        I_WREN = w; I_ADDR = a; I_WDATA = d; KEYB_STB = k; MOUSE_STB = m;
    endtask

    initial begin
        logic exp_t;
        RESET = 1'b1;
        drive(1'b0, A0, 8'h00, 1'b0, 1'b0);

        // Expected state is that after the edge ending each vector's cycle.
        // Basic delivery and ACK gating
        add(1, A0, 8'h07, 0, 0, 3'b000, 1, 8'h07);
        add(0, A0, 8'h00, 1, 0, 3'b000, 1, 8'h17);
        add(0, A3, 8'h00, 0, 0, 3'b001, 1, 8'h01);
        add(0, A0, 8'h00, 1, 0, 3'b001, 1, 8'h17);
        add(0, A0, 8'h00, 0, 0, 3'b001, 1, 8'h17);
        add(1, A3, 8'h01, 0, 0, 3'b001, 1, 8'h00);
        add(0, A3, 8'h00, 0, 0, 3'b000, 1, 8'h01);
        add(1, A3, 8'h01, 0, 0, 3'b000, 1, 8'h00);
        // Simultaneous keyboard and mouse strobes
        add(0, A0, 8'h00, 1, 1, 3'b000, 1, 8'h37);
        add(0, A3, 8'h00, 0, 0, 3'b001, 1, 8'h01);
        add(1, A3, 8'h01, 0, 0, 3'b001, 1, 8'h00);
        add(0, A0, 8'h00, 0, 0, 3'b011, 1, 8'h07);
        add(1, A3, 8'h02, 0, 0, 3'b011, 1, 8'h00);
        // Masked pending, then unmask
        add(1, A0, 8'h00, 0, 0, 3'b011, 1, 8'h00);
        add(0, A0, 8'h00, 0, 1, 3'b011, 1, 8'h20);
        add(0, A0, 8'h00, 0, 0, 3'b011, 1, 8'h20);
        add(1, A0, 8'h02, 0, 0, 3'b011, 1, 8'h22);
        add(0, A3, 8'h00, 0, 0, 3'b001, 1, 8'h02);
        add(1, A3, 8'h02, 0, 0, 3'b001, 1, 8'h00);
        // Window boundaries and ACK of a non-inflight bit
        add(1, 16'hFFF4, 8'hFF, 0, 0, 3'b001, 0, 8'h00);
        add(1, 16'hFFEF, 8'hFF, 0, 0, 3'b001, 0, 8'h00);
        add(0, A0, 8'h00, 0, 0, 3'b001, 1, 8'h02);
        add(1, A3, 8'h04, 0, 0, 3'b001, 1, 8'h00);
        // Overrun while keyboard pending and mouse inflight
        add(1, A0, 8'h07, 0, 0, 3'b001, 1, 8'h07);
        add(0, A3, 8'h00, 0, 1, 3'b001, 1, 8'h00);
        add(0, A3, 8'h00, 0, 0, 3'b011, 1, 8'h02);
        add(0, A3, 8'h00, 1, 0, 3'b011, 1, 8'h02);
        add(0, A3, 8'h00, 1, 0, 3'b011, 1, 8'h12);
        add(0, A3, 8'h00, 1, 0, 3'b011, 1, 8'h12);
        add(0, A0, 8'h00, 0, 0, 3'b011, 1, 8'h17);
        add(1, A3, 8'h80, 0, 0, 3'b011, 1, 8'h02);
        add(1, A3, 8'h02, 0, 0, 3'b011, 1, 8'h00);
        add(0, A3, 8'h00, 0, 0, 3'b010, 1, 8'h01);
        add(0, A0, 8'h00, 0, 0, 3'b010, 1, 8'h07);
        add(1, A3, 8'h01, 0, 0, 3'b010, 1, 8'h00);
        // Strobe in the same cycle its pending bit is delivered
        add(0, A0, 8'h00, 1, 0, 3'b010, 1, 8'h17);
        add(0, A3, 8'h00, 1, 0, 3'b011, 1, 8'h01);
        add(0, A0, 8'h00, 0, 0, 3'b011, 1, 8'h17);
        add(1, A3, 8'h01, 0, 0, 3'b011, 1, 8'h00);
        add(0, A3, 8'h00, 0, 0, 3'b010, 1, 8'h01);
        add(1, A3, 8'h01, 0, 0, 3'b010, 1, 8'h00);

        step;
        step;
        chk("reset_irq", {IRQ_TIMER, IRQ_MOUSE, IRQ_KEYB}, 3'b000);
        for (int r = 0; r < 4; r++) begin
            I_ADDR = A0 + 16'(r);
            #1;
            chk($sformatf("reset_reg%0d", r), {O_RSEL, O_RDATA}, {1'b1, 8'h00});
        end
        I_ADDR = A0;
        RESET = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].wren, vq[i].addr, vq[i].wdata, vq[i].k, vq[i].m);
            step;
            chk($sformatf("vec%0d_irq", i), {IRQ_TIMER, IRQ_MOUSE, IRQ_KEYB}, vq[i].irq);
            chk($sformatf("vec%0d_rd", i), {O_RSEL, O_RDATA}, {vq[i].rsel, vq[i].rdata});
        end

        // Timer: period 3 ticks of 4 cycles, toggle one cycle after each fire
        drive(1, A0, 8'h04, 0, 0); step;
        drive(1, A1, 8'h03, 0, 0); step;
        drive(1, A2, 8'h00, 0, 0); step;
        I_WREN = 1'b0;
        I_ADDR = A1; #1;
        chk("tperiod_lo", O_RDATA, 8'h03);
        I_ADDR = A2; #1;
        chk("tperiod_hi", O_RDATA, 8'h00);
        I_ADDR = A3;
        for (int e = 1; e <= 40; e++) begin
            I_WREN  = (e == 14 || e == 26);
            I_WDATA = 8'h04;
            step;
            exp_t = (e >= 13 && e < 25) || (e >= 37);
            chk($sformatf("timer_e%0d", e), IRQ_TIMER, exp_t);
        end
        I_WREN = 1'b0;
        chk("timer_inflight", O_RDATA, 8'h04);

        // Asynchronous reset mid-interval, no clock edge in between
        #2;
        RESET = 1'b1;
        #1;
        chk("async_irq", {IRQ_TIMER, IRQ_MOUSE, IRQ_KEYB}, 3'b000);
        for (int r = 0; r < 4; r++) begin
            I_ADDR = A0 + 16'(r);
            #1;
            chk($sformatf("async_reg%0d", r), O_RDATA, 8'h00);
        end
        step;
        RESET = 1'b0;

        drive(1, A0, 8'h01, 0, 0); step;
        drive(0, A0, 8'h00, 1, 0); step;
        drive(0, A3, 8'h00, 0, 0); step;
        chk("post_reset_keyb", {IRQ_TIMER, IRQ_MOUSE, IRQ_KEYB}, 3'b001);
        chk("post_reset_inflight", O_RDATA, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
